mau_host: RTL
=============

Name: mau_host

Overview:
Host-side master for the MAU parallel-SPI link: the initiator that drives the MAU's RX/TX ports.
- Accepts one 40-bit instruction over a valid/ready command port and serialises it as 5 bytes on an 8-bit MOSI bus.
- After a fixed compute gap, reads back the 18-bit result plus carry as 3 bytes.
- Returns the result on a valid/ready response port.
- Used as the FPGA/bench-side controller and as the reusable driver in MAU system testbenches.

Parameters:
- CLK_DIV, 2, spi_clk half-period in clk cycles (legal ≥1).
- RESULT_WAIT, 8, clk cycles between end of the write burst and start of the read burst (legal ≥1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  instruction offered
- cmd_ready  out  1  host idle, instruction accepted on cmd_valid&cmd_ready
- cmd_data  in  40  {op, a1, a2, b1, b2}, op in [39:32]
- rsp_valid  out  1  result available
- rsp_ready  in  1  result consumed on rsp_valid&rsp_ready
- rsp_data  out  18  result
- rsp_carry  out  1  result carry
- busy  out  1  transaction in progress (~cmd_ready)
- spi_clk  out  1  link clock to MAU
- spi_w  out  1  write strobe
- spi_r  out  1  read strobe
- mosi  out  8  instruction byte to MAU ui_in
- miso  in  8  result byte from MAU ui_out
- carry_in  in  1  MAU res_carry

Behaviour:
Reset (async assert, sync release):
- cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_carry=0, busy=0.
- spi_clk=0, spi_w=0, spi_r=0, mosi=0.
- Internal byte and phase counters=0, state=IDLE.

FSM states: IDLE, WRITE, GAP, READ, RESP.
- IDLE: cmd_ready=1. On handshake edge t0, latch cmd_data and go to WRITE. cmd_valid outside IDLE is ignored (cmd_ready=0).
- WRITE: 5 bytes, order op, a1, a2, b1, b2.
  - Per byte: mosi=byte and spi_w=1 with spi_clk=0 for CLK_DIV cycles, then spi_clk=1 for CLK_DIV cycles. The MAU samples on the spi_clk rise.
  - mosi changes only while spi_clk=0.
  - After the 5th high phase: spi_clk=0, spi_w=0, mosi=0, go to GAP.
- GAP: spi_clk held 0 for RESULT_WAIT cycles, then go to READ.
- READ: spi_r=1 for 3 spi_clk periods (low CLK_DIV, high CLK_DIV). The MAU drives miso after the rise; the host samples miso on each spi_clk fall.
  - Byte 0 → rsp_data[7:0].
  - Byte 1 → rsp_data[15:8].
  - Byte 2 → rsp_data[17:16] = miso[1:0]; miso[7:2] ignored.
  - carry_in is sampled at the 3rd fall into rsp_carry.
  - After the 3rd fall: spi_r=0, spi_clk=0, go to RESP.
- RESP: rsp_valid=1. rsp_data and rsp_carry are held stable until rsp_ready. On the handshake edge, rsp_valid=0 and state returns to IDLE. rsp_data keeps its last value.

Timing and latency:
- rsp_valid first high in clk cycle t0 + 16·CLK_DIV + RESULT_WAIT.
- Minimum command-to-command spacing is that latency + 1 cycle when rsp_ready is held high.
- spi_clk is a register output, glitch-free, and toggles only in WRITE and READ.
- spi_w and spi_r are never high simultaneously.

Boundary conditions:
- CLK_DIV=1 gives spi_clk=clk/2 and must work.
- rsp_ready held low stalls indefinitely in RESP. No new command is accepted and no SPI activity occurs.
- rsp_ready high on the same edge rsp_valid rises: completes immediately, so rsp_valid is high for 1 cycle.
- Reset asserted mid-WRITE or mid-READ: all outputs take reset values immediately (async). The partial transfer is abandoned with no rsp. The MAU is reset by the same rst_n.

Decomposition:
- Shared package mau_pkg:
  - alu_ctrl_t lives here.
  - MAU_INSTR_BYTES=5, MAU_RES_BYTES=3, MAU_RES_W=18.
  - Opcode constants for VADD2, VSUB2, DIFF2, DET2, DIST2, POLY, SCMULX.
- Sub-module mau_host_sclk: divider producing spi_clk plus one-cycle rise/fall strobes, with an enable input.
- The main FSM consumes the strobes.

Test Plan:
1. Reset: release rst_n with no command → cmd_ready=1, all SPI outputs 0, rsp_valid=0 for 100 cycles.
2. Single command, CLK_DIV=2, RESULT_WAIT=4, cmd_data=40'h11_22_33_44_55; MAU model returns miso bytes C3, A5, FE and carry_in=1 → mosi sequence 11, 22, 33, 44, 55 sampled on 5 rises with spi_w=1; rsp_valid at t0+36; rsp_data=18'h2A5C3, rsp_carry=1.
3. Back-pressure: rsp_ready=0 for 20 cycles after rsp_valid → rsp_data stable, cmd_ready=0, spi_clk static; rsp_ready=1 → returns to IDLE next cycle.
4. Back-to-back: two commands with rsp_ready tied high and cmd_valid held → second handshake exactly 1 cycle after the first rsp handshake; both responses correct.
5. Reset mid-write: assert rst_n=0 during the 3rd byte → spi_w/spi_clk/mosi=0 asynchronously, no rsp_valid; a new command after release completes normally.
6. CLK_DIV=1, RESULT_WAIT=1 → spi_clk period 2 clk, rsp_valid at t0+17, correct data.

Source files
------------

// File: rtl/mau_pkg.sv
// Shared MAU definitions: link framing constants, ALU opcodes and the host FSM state type.
package mau_pkg;

    localparam int MAU_INSTR_BYTES = 5;
    localparam int MAU_RES_BYTES   = 3;
    localparam int MAU_RES_W       = 18;

    typedef enum logic [7:0] {
        ALU_VADD2  = 8'h01,
        ALU_VSUB2  = 8'h02,
        ALU_DIFF2  = 8'h03,
        ALU_DET2   = 8'h04,
        ALU_DIST2  = 8'h05,
        ALU_POLY   = 8'h06,
        ALU_SCMULX = 8'h07
    } alu_ctrl_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_GAP,
        ST_READ,
        ST_RESP
    } host_state_t;

endpackage

// File: rtl/mau_host_sclk.sv
// spi_clk divider: CLK_DIV cycles low, CLK_DIV cycles high while enabled, parked low otherwise.
// rise/fall are asserted in the cycle before the edge they announce.
module mau_host_sclk #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic spi_clk,
    output logic rise,
    output logic fall
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap = en && (cnt == CW'(CLK_DIV - 1));
    assign rise = wrap && !spi_clk;
    assign fall = wrap && spi_clk;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            spi_clk <= 1'b0;
        end else if (!en) begin
            cnt     <= '0;
            spi_clk <= 1'b0;
        end else if (wrap) begin
            cnt     <= '0;
            spi_clk <= ~spi_clk;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mau_host.sv
// Host-side master for the MAU parallel-SPI link: writes a 5-byte instruction,
// waits a fixed compute gap, reads back the 18-bit result plus carry.
module mau_host
    import mau_pkg::*;
#(
    parameter int CLK_DIV     = 2,
    parameter int RESULT_WAIT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [39:0]          cmd_data,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [MAU_RES_W-1:0] rsp_data,
    output logic                 rsp_carry,
    output logic                 busy,
    output logic                 spi_clk,
    output logic                 spi_w,
    output logic                 spi_r,
    output logic [7:0]           mosi,
    input  logic [7:0]           miso,
    input  logic                 carry_in
);

    localparam int GW = (RESULT_WAIT > 1) ? $clog2(RESULT_WAIT) : 1;

    host_state_t   state, state_next;
    logic          sclk_en, sclk_rise, sclk_fall;
    logic [2:0]    byte_cnt;
    logic [GW-1:0] gap_cnt;
    logic [39:0]   sreg;
    logic [15:0]   res_buf;
    logic          gap_done;

    assign sclk_en  = (state == ST_WRITE) || (state == ST_READ);
    assign gap_done = (gap_cnt == GW'(RESULT_WAIT - 1));
    assign mosi     = sreg[39:32];
    assign busy     = ~cmd_ready;

    mau_host_sclk #(.CLK_DIV(CLK_DIV)) u_sclk (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (sclk_en),
        .spi_clk (spi_clk),
        .rise    (sclk_rise),
        .fall    (sclk_fall)
    );

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (cmd_valid) state_next = ST_WRITE;
            ST_WRITE: if (sclk_fall && byte_cnt == 3'(MAU_INSTR_BYTES)) state_next = ST_GAP;
            ST_GAP:   if (gap_done) state_next = ST_READ;
            ST_READ:  if (sclk_fall && byte_cnt == 3'(MAU_RES_BYTES - 1)) state_next = ST_RESP;
            ST_RESP:  if (rsp_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they leave flops glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            spi_w     <= 1'b0;
            spi_r     <= 1'b0;
        end else begin
            state     <= state_next;
            cmd_ready <= (state_next == ST_IDLE);
            rsp_valid <= (state_next == ST_RESP);
            spi_w     <= (state_next == ST_WRITE);
            spi_r     <= (state_next == ST_READ);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg      <= '0;
            byte_cnt  <= '0;
            gap_cnt   <= '0;
            res_buf   <= '0;
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
        end else begin
            gap_cnt <= (state == ST_GAP) ? gap_cnt + GW'(1) : '0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        sreg     <= cmd_data;
                        byte_cnt <= '0;
                    end
                end
                ST_WRITE: begin
                    // Bytes are counted as the MAU takes them (rise); mosi advances on the fall,
                    // and after the last fall the shifter has emptied so mosi parks at zero.
                    if (sclk_rise) byte_cnt <= byte_cnt + 3'd1;
                    if (sclk_fall) begin
                        sreg <= {sreg[31:0], 8'h00};
                        if (byte_cnt == 3'(MAU_INSTR_BYTES)) byte_cnt <= '0;
                    end
                end
                ST_READ: begin
                    if (sclk_fall) begin
                        byte_cnt <= byte_cnt + 3'd1;
                        case (byte_cnt)
                            3'd0:    res_buf[7:0]  <= miso;
                            3'd1:    res_buf[15:8] <= miso;
                            default: begin
                                rsp_data  <= {miso[1:0], res_buf};
                                rsp_carry <= carry_in;
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
